rv32i_trace_capture: RTL
========================

Name: rv32i_trace_capture

Overview:
- Consumer end of the CPU debug/monitor bus. Samples the core's per-cycle writeback, store, branch and jump outputs and turns qualifying events into fixed-format trace records.
- Records are buffered in a small FIFO and streamed out as 32-bit words over a valid/ready handshake.
- Sits beside rv32i_top in the hardware tracer or on-chip logger, fed by the same signals the testbench monitor samples.

Parameters:
- DEPTH, 8, record FIFO depth in records; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all logic on posedge
- arst_n  in  1  reset, asynchronous, active-low
- trace_en  in  1  capture enable; gates new captures only
- pc_out  in  32  PC of the monitored instruction
- instruction  in  32  monitored instruction word
- wb_data  in  32  writeback data
- rd_addr  in  5  destination register
- reg_write  in  1  register write strobe
- mem_write  in  1  store strobe
- mem_addr  in  32  store address
- mem_wdata  in  32  store data
- branch_taken  in  1  taken branch
- jal  in  1  JAL executed
- jalr  in  1  JALR executed
- t_valid  out  1  output word valid
- t_ready  in  1  downstream accepts word
- t_data  out  32  output word
- t_last  out  1  last word of record
- fifo_level  out  $clog2(DEPTH)+1  records stored, including any record being streamed
- overflow  out  1  sticky: at least one event dropped since reset

Behaviour:
- Event: trace_en & ((reg_write & rd_addr!=0) | mem_write | branch_taken | jal | jalr), sampled each posedge.
- Capture: on an event with FIFO not full, store {pc_out, instruction, data, flags}.
  - data = mem_write ? mem_addr : wb_data.
  - fifo_level increments.
- Header word W0:
  - [31:24] seq, 8-bit, wraps 255->0, increments per accepted record.
  - [23:16] drops since the previous accepted record, saturating at 255.
  - [15:11] rd_addr.
  - [10] reg_write, [9] mem_write, [8] branch_taken, [7] jal, [6] jalr.
  - [5:0] record length in words.
- Record words in order: W0 header, W1 pc, W2 instruction, W3 data. Length is 4.
- Full: an event arriving while fifo_level==DEPTH is dropped.
  - The drop counter increments (saturating); overflow sets and stays set until reset.
  - seq does not advance on a drop.
  - The drop counter clears when it is written into an accepted header.
- Simultaneous event and final-word pop while full: fullness is evaluated before the pop, so the event is dropped.
- Serializer FSM states: IDLE, HDR, PC, INSN, DATA (plus WDATA under the optional feature).
  - IDLE->HDR when FIFO not empty.
  - Each state advances on t_valid & t_ready.
  - Last state pops the record; goes to HDR if the FIFO is still non-empty, else IDLE.
- t_valid=1 in every non-IDLE state. t_data and t_last are held stable while t_valid & !t_ready.
- t_last=1 only in the final state of a record.
- Latency: event at posedge N gives t_valid=1 with W0 in cycle N+1 when the FIFO was empty; back-to-back records stream with no idle cycle.
- trace_en deasserted mid-record: the in-flight record and buffered records still drain; only new captures stop.
- Reset (arst_n=0, asynchronous):
  - t_valid=0, t_data=0, t_last=0, fifo_level=0, overflow=0.
  - seq=0, drop counter=0, FSM=IDLE, FIFO emptied.
  - A partially sent record is discarded.

Optional Feature:
- Macro TRACE_MEMDATA_EN.
- Defined:
  - Records of events with mem_write=1 carry a 5th word W4 = mem_wdata.
  - Header length = 5 for those records; the WDATA state follows DATA and carries t_last.
  - Non-store records stay at 4 words.
- Undefined: all records are 4 words and mem_wdata is ignored (input port still present).

Test Plan:
- Reset, then trace_en=1 with reg_write=1, rd_addr=5, wb_data=0xDEADBEEF, pc_out=0x100, instruction=0x00500293 for one cycle, t_ready=1 -> 4 words starting the next cycle: 0x00002C04 (seq 0, drops 0, rd_addr 5, reg_write, len 4), 0x00000100, 0x00500293, 0xDEADBEEF; t_last only on the 4th word.
- Event with reg_write=1, rd_addr=0 and no other flags -> no record; fifo_level stays 0.
- t_ready=0 and DEPTH+3 (=11) consecutive events:
  - fifo_level reaches 8 and overflow=1.
  - After releasing t_ready, 8 records drain with seq 0..7.
  - The next accepted event's header shows seq 8 and drops 3.
- mem_write=1, mem_addr=0x2000, mem_wdata=0x55:
  - W3 = 0x2000.
  - With TRACE_MEMDATA_EN: 5 words, len 5, W4 = 0x55, t_last on W4.
- Toggle t_ready 1/0 every cycle during a record -> t_data is stable on stalled cycles and no word is lost or duplicated.
- arst_n pulsed low while W2 is on the bus -> outputs go to 0 immediately; the next event after reset produces a header with seq 0.

Source files
------------

// File: rtl/rv32i_trace_capture_if.sv
// Monitor-bus / trace-stream bundle for rv32i_trace_capture.
// The slave side (the capture block) samples the core's per-cycle monitor
// signals and drives the 32-bit trace word stream; the master side is the
// core monitor together with the downstream word consumer.
interface rv32i_trace_capture_if;
    // core monitor signals
    logic        trace_en;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    // trace word stream
    logic        t_valid;
    logic        t_ready;
    logic [31:0] t_data;
    logic        t_last;

    modport master (
        output trace_en, pc_out, instruction, wb_data, rd_addr, reg_write,
               mem_write, mem_addr, mem_wdata, branch_taken, jal, jalr,
               t_ready,
        input  t_valid, t_data, t_last
    );

    modport slave (
        input  trace_en, pc_out, instruction, wb_data, rd_addr, reg_write,
               mem_write, mem_addr, mem_wdata, branch_taken, jal, jalr,
               t_ready,
        output t_valid, t_data, t_last
    );
endinterface

// File: rtl/rv32i_trace_capture.sv
// rv32i_trace_capture: turns qualifying RV32I writeback/store/branch/jump
// events into fixed-format trace records, buffers them in a record FIFO and
// streams them out one 32-bit word per handshake.
// Record: W0 header {seq, drops, rd_addr, flags, len}, W1 pc, W2 instruction,
// W3 data (store address for stores, writeback data otherwise).
// Optional feature, macro TRACE_MEMDATA_EN: store records carry a fifth word
// W4 = mem_wdata and report length 5. Without it every record is 4 words and
// mem_wdata is ignored.
module rv32i_trace_capture #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     arst_n,
    rv32i_trace_capture_if.slave     bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Saturating increment for the 8-bit drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Record length in words for the event being captured.
    function automatic logic [5:0] rec_len(input logic is_store);
`ifdef TRACE_MEMDATA_EN
        return is_store ? 6'd5 : 6'd4;
`else
        return (is_store & 1'b0) ? 6'd5 : 6'd4;
`endif
    endfunction

`ifdef TRACE_MEMDATA_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        PC    = 3'd2,
        INSN  = 3'd3,
        DATA  = 3'd4,
        WDATA = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        PC    = 3'd2,
        INSN  = 3'd3,
        DATA  = 3'd4
    } state_t;
`endif

    state_t state, state_nxt;

    // control state
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic [7:0]    seq;
    logic [7:0]    drop_cnt;

    // capture stage (combinational view of the monitor bus)
    logic        event_p0;
    logic        full_p0;
    logic        push_p0;
    logic        drop_p0;
    logic [31:0] hdr_p0;
    logic [31:0] data_p0;

    // record storage (data only, never reset)
    logic [31:0] hdr_mem_p1  [DEPTH];
    logic [31:0] pc_mem_p1   [DEPTH];
    logic [31:0] insn_mem_p1 [DEPTH];
    logic [31:0] data_mem_p1 [DEPTH];
`ifdef TRACE_MEMDATA_EN
    logic [31:0] wdata_mem_p1 [DEPTH];
`else
    logic        unused_wdata;
`endif

    // serializer view of the FIFO head
    logic [31:0] head_hdr, head_pc, head_insn, head_data;
    logic        pop;
    logic        rec_done;
    logic        out_valid, out_last;
    logic [31:0] out_data;

    // ---- stage p0: event qualification and record assembly ----
    assign event_p0 = bus.trace_en &
                      ((bus.reg_write & (bus.rd_addr != 5'd0)) |
                       bus.mem_write | bus.branch_taken | bus.jal | bus.jalr);
    // fullness uses the registered level, so a same-cycle pop cannot make room
    assign full_p0  = (count == LW'(DEPTH));
    assign push_p0  = event_p0 & ~full_p0;
    assign drop_p0  = event_p0 & full_p0;
    assign data_p0  = bus.mem_write ? bus.mem_addr : bus.wb_data;
    assign hdr_p0   = {seq, drop_cnt, bus.rd_addr,
                       bus.reg_write, bus.mem_write, bus.branch_taken,
                       bus.jal, bus.jalr, rec_len(bus.mem_write)};

`ifndef TRACE_MEMDATA_EN
    assign unused_wdata = ^bus.mem_wdata;
`endif

    // ---- stage p1: record FIFO storage ----
    // Write the assembled record into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            hdr_mem_p1[wr_ptr]  <= hdr_p0;
            pc_mem_p1[wr_ptr]   <= bus.pc_out;
            insn_mem_p1[wr_ptr] <= bus.instruction;
            data_mem_p1[wr_ptr] <= data_p0;
`ifdef TRACE_MEMDATA_EN
            wdata_mem_p1[wr_ptr] <= bus.mem_wdata;
`endif
        end
    end

    assign head_hdr  = hdr_mem_p1[rd_ptr];
    assign head_pc   = pc_mem_p1[rd_ptr];
    assign head_insn = insn_mem_p1[rd_ptr];
    assign head_data = data_mem_p1[rd_ptr];

    // Pointers and record count; the head record stays counted until its
    // final word has been accepted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_p0) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_p0, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequence number, drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            seq      <= 8'd0;
            drop_cnt <= 8'd0;
            overflow <= 1'b0;
        end else if (push_p0) begin
            seq      <= seq + 8'd1;
            drop_cnt <= 8'd0;
        end else if (drop_p0) begin
            drop_cnt <= sat_inc8(drop_cnt);
            overflow <= 1'b1;
        end
    end

    assign fifo_level = count;

    // ---- stage p2: record serializer ----
`ifdef TRACE_MEMDATA_EN
    assign rec_done = ((state == DATA) & (head_hdr[5:0] != 6'd5)) |
                      (state == WDATA);
`else
    assign rec_done = (state == DATA);
`endif
    assign pop = rec_done & bus.t_ready;

    // Serializer state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Serializer next-state: one word per accepted handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if ((count != '0) || push_p0) state_nxt = HDR;
            HDR:  if (bus.t_ready) state_nxt = PC;
            PC:   if (bus.t_ready) state_nxt = INSN;
            INSN: if (bus.t_ready) state_nxt = DATA;
            DATA: begin
                if (bus.t_ready) begin
`ifdef TRACE_MEMDATA_EN
                    if (head_hdr[5:0] == 6'd5)
                        state_nxt = WDATA;
                    else
`endif
                    if ((count > LW'(1)) || push_p0)
                        state_nxt = HDR;
                    else
                        state_nxt = IDLE;
                end
            end
`ifdef TRACE_MEMDATA_EN
            WDATA: begin
                if (bus.t_ready) begin
                    if ((count > LW'(1)) || push_p0) state_nxt = HDR;
                    else                             state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Serializer outputs; word content depends only on state and FIFO head,
    // so it holds steady while the consumer stalls.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'd0;
        case (state)
            HDR: begin
                out_valid = 1'b1;
                out_data  = head_hdr;
            end
            PC: begin
                out_valid = 1'b1;
                out_data  = head_pc;
            end
            INSN: begin
                out_valid = 1'b1;
                out_data  = head_insn;
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = head_data;
                out_last  = rec_done;
            end
`ifdef TRACE_MEMDATA_EN
            WDATA: begin
                out_valid = 1'b1;
                out_data  = wdata_mem_p1[rd_ptr];
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
                out_last  = 1'b0;
                out_data  = 32'd0;
            end
        endcase
    end

    assign bus.t_valid = out_valid;
    assign bus.t_data  = out_data;
    assign bus.t_last  = out_last;

endmodule
